// File: rtl/simple_log_64.sv
// Circular trace log: stamps each accepted event word with a free-running cycle count and stores it in a simple dual-port RAM.
// Latency: a read request in cycle N returns its entry in cycle N+1. Pointer and wrap flag update the cycle after a write.
// Backpressure: none. Every write and every read request is accepted, at up to one of each per cycle.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   log_en, wr_val, wr_data            event capture; writes are recorded only while log_en=1
//   log_rd_req_val, log_rd_req_addr    single-beat read request
//   log_rd_resp_val, log_rd_resp_data  read response, entry = {timestamp, data}
//   curr_wr_addr, has_wrapped          next write index and sticky wrap flag, used to locate the valid window
module simple_log_64 #(
    parameter int ADDR_W             = 8,
    parameter int DATA_W             = 64,
    parameter int TS_W               = 32,
    parameter int RESP_DATA_STRUCT_W = TS_W + DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          log_en,
    input  logic                          wr_val,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          log_rd_req_val,
    input  logic [ADDR_W-1:0]             log_rd_req_addr,
    output logic                          log_rd_resp_val,
    output logic [RESP_DATA_STRUCT_W-1:0] log_rd_resp_data,
    output logic [ADDR_W-1:0]             curr_wr_addr,
    output logic                          has_wrapped
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [TS_W-1:0]               ts_cnt;
    logic                          wr_fire;
    logic                          resp_val_q;
    logic [RESP_DATA_STRUCT_W-1:0] mem [DEPTH];

    // A write presented during reset is dropped, so rst is folded into the enable.
    assign wr_fire = wr_val && log_en && !rst;

    // Free-running timestamp; keeps counting while the log is frozen so gaps stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Write pointer and sticky wrap flag. The flag sets on the write that
    // consumes the last slot, i.e. it rises together with the pointer rolling to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_wr_addr <= '0;
            has_wrapped  <= 1'b0;
        end else if (wr_fire) begin
            curr_wr_addr <= curr_wr_addr + ADDR_W'(1);
            if (&curr_wr_addr) begin
                has_wrapped <= 1'b1;
            end
        end
    end

    // RAM write port, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[curr_wr_addr] <= {ts_cnt, wr_data};
        end
    end

    // RAM read port with registered output. Reading in the same always_ff edge
    // as the write gives read-first behaviour on an address collision. The data
    // register only loads on a request, so it holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_val_q       <= 1'b0;
            log_rd_resp_data <= '0;
        end else begin
            resp_val_q <= log_rd_req_val;
            if (log_rd_req_val) begin
                log_rd_resp_data <= mem[log_rd_req_addr];
            end
        end
    end

    // A request issued just before reset must not surface while rst is high,
    // so the registered valid is masked by rst for that one cycle.
    assign log_rd_resp_val = resp_val_q && !rst;

endmodule
